// File: rtl/p2_pkt_pkg.sv
// Shared constants and types for the protocol-2 DDC UDP packetizer.
package p2_pkt_pkg;

    localparam int unsigned HDR_BYTES         = 16;
    localparam int unsigned DDC_PAYLOAD_BYTES = 1428;
    localparam int unsigned DDC_PACKET_BYTES  = HDR_BYTES + DDC_PAYLOAD_BYTES;
    localparam int unsigned HDR_W             = HDR_BYTES * 8;

    // Header byte offsets, byte 0 is transmitted first.
    localparam int unsigned HDR_SEQ_OFS = 0;
    localparam int unsigned HDR_TS_OFS  = 4;
    localparam int unsigned HDR_BPS_OFS = 12;
    localparam int unsigned HDR_SPF_OFS = 14;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HDR,
        DATA,
        DONE
    } pkt_state_e;

endpackage

// File: rtl/rx_udp_packetizer_if.sv
// FIFO read side and Ethernet Tx arbiter side of one receiver's packetizer.
interface rx_udp_packetizer_if #(
    parameter int unsigned USEDW_W = 11
);
    logic [USEDW_W-1:0] fifo_usedw;
    logic [7:0]         fifo_rddata;
    logic               fifo_rdreq;
    logic               tx_req;
    logic               tx_ack;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_last;
    logic [3:0]         tx_port_id;

    modport master (
        input  fifo_usedw, fifo_rddata, tx_ack,
        output fifo_rdreq, tx_req, tx_data, tx_valid, tx_last, tx_port_id
    );

    modport slave (
        output fifo_usedw, fifo_rddata, tx_ack,
        input  fifo_rdreq, tx_req, tx_data, tx_valid, tx_last, tx_port_id
    );
endinterface

// File: rtl/p2_hdr_shift.sv
// 16-byte header shadow: parallel load, then shifts out one byte per clock MSB first.
module p2_hdr_shift
    import p2_pkt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [HDR_W-1:0] hdr_i,
    output logic [7:0]       byte_o
);

    logic [HDR_W-1:0] hdr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q <= '0;
        end else if (load_i) begin
            hdr_q <= hdr_i;
        end else if (shift_i) begin
            hdr_q <= {hdr_q[HDR_W-9:0], 8'h00};
        end
    end

    assign byte_o = hdr_q[HDR_W-1 -: 8];

endmodule

// File: rtl/rx_udp_packetizer.sv
// Streams one DDC UDP payload (16-byte header + FIFO I/Q bytes) per arbiter grant.
// Optional: define RX_TIMESTAMP_EN to put a free-running 64-bit clock count in header bytes 4-11.
module rx_udp_packetizer
    import p2_pkt_pkg::*;
#(
    parameter int unsigned NR              = 0,
    parameter int unsigned PAYLOAD_BYTES   = DDC_PAYLOAD_BYTES,
    parameter int unsigned BITS_PER_SAMPLE = 24,
    parameter int unsigned USEDW_W         = 11
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    rx_udp_packetizer_if.master  bus,
    output logic [31:0]          seq_out
);

    localparam int unsigned CNT_W = $clog2(PAYLOAD_BYTES);

    pkt_state_e       state_q;
    logic             run_d_q;
    logic             clr_pend_q;
    logic [31:0]      seq_q;
    logic [31:0]      seq_out_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tx_req_q;
    logic             tx_valid_q;
    logic             tx_last_q;
    logic             rdreq_q;

    logic             run_rise_c;
    logic             thresh_c;
    logic             hdr_load_c;
    logic             hdr_shift_c;
    logic [63:0]      ts_c;
    logic [HDR_W-1:0] hdr_c;
    logic [7:0]       hdr_byte;

`ifdef RX_TIMESTAMP_EN
    logic [63:0] ts_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 64'd1;
        end
    end

    assign ts_c = ts_q;
`else
    assign ts_c = '0;
`endif

    assign run_rise_c  = run & ~run_d_q;
    assign thresh_c    = bus.fifo_usedw >= USEDW_W'(PAYLOAD_BYTES);
    assign hdr_load_c  = (state_q == REQ) && bus.tx_ack;
    assign hdr_shift_c = (state_q == HDR);

    // Header image captured at grant time.
    always_comb begin
        hdr_c = '0;
        hdr_c[HDR_W-1-8*HDR_SEQ_OFS -: 32] = seq_q;
        hdr_c[HDR_W-1-8*HDR_TS_OFS  -: 64] = ts_c;
        hdr_c[HDR_W-1-8*HDR_BPS_OFS -: 16] = 16'(BITS_PER_SAMPLE);
        hdr_c[HDR_W-1-8*HDR_SPF_OFS -: 16] = 16'(PAYLOAD_BYTES / 6);
    end

    p2_hdr_shift u_hdr (
        .clk     (clock),
        .rst_n   (reset),
        .load_i  (hdr_load_c),
        .shift_i (hdr_shift_c),
        .hdr_i   (hdr_c),
        .byte_o  (hdr_byte)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            run_d_q    <= 1'b0;
            clr_pend_q <= 1'b0;
            seq_q      <= '0;
            seq_out_q  <= '0;
            cnt_q      <= '0;
            tx_req_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            rdreq_q    <= 1'b0;
        end else begin
            run_d_q <= run;
            // A run restart outside IDLE is remembered and applied at the next IDLE.
            if (run_rise_c && (state_q != IDLE)) begin
                clr_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (run_rise_c || clr_pend_q) begin
                        seq_q <= '0;
                    end
                    clr_pend_q <= 1'b0;
                    if (run && thresh_c) begin
                        state_q  <= REQ;
                        tx_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.tx_ack) begin
                        state_q    <= HDR;
                        cnt_q      <= '0;
                        tx_valid_q <= 1'b1;
                        seq_out_q  <= seq_q;
                    end else if (!run) begin
                        state_q  <= IDLE;
                        tx_req_q <= 1'b0;
                    end
                end
                HDR: begin
                    if (cnt_q == CNT_W'(HDR_BYTES - 1)) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        rdreq_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(PAYLOAD_BYTES - 2)) begin
                        tx_last_q <= 1'b1;
                    end
                    if (tx_last_q) begin
                        state_q    <= DONE;
                        tx_req_q   <= 1'b0;
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                        rdreq_q    <= 1'b0;
                    end
                end
                DONE: begin
                    seq_q   <= seq_q + 32'd1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Show-ahead FIFO: the pop strobe and the byte it exposes share the cycle.
    assign bus.fifo_rdreq = rdreq_q;
    assign bus.tx_data    = rdreq_q ? bus.fifo_rddata : hdr_byte;
    assign bus.tx_req     = tx_req_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_last    = tx_last_q;
    assign bus.tx_port_id = 4'(NR);
    assign seq_out        = seq_out_q;

endmodule

// File: tb/tb_rx_udp_packetizer.sv
// Scoreboard bench for rx_udp_packetizer: FIFO model, arbiter model, byte-level monitor.
module tb_rx_udp_packetizer;
    import p2_pkt_pkg::*;

    localparam int unsigned USEDW_W = 11;
    localparam int unsigned PAY     = DDC_PAYLOAD_BYTES;

    typedef struct {
        logic [7:0] data;
        bit         last;
        bit         care;
        bit         is_data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run   = 1'b0;
    logic [31:0] seq_out;

    rx_udp_packetizer_if #(.USEDW_W(USEDW_W)) bus ();

    rx_udp_packetizer #(
        .NR              (0),
        .PAYLOAD_BYTES   (PAY),
        .BITS_PER_SAMPLE (24),
        .USEDW_W         (USEDW_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .bus     (bus),
        .seq_out (seq_out)
    );

    always #5 clock = ~clock;

    exp_t        exp_q[$];
    logic [7:0]  fifo_q[$];
    logic [7:0]  ref_q[$];
    logic [7:0]  saved_q[$];
    logic [63:0] ts_list[$];
    longint      grant_cyc[$];
    int          errors = 0;
    int          checks = 0;
    int          idx = 0;
    bit          in_pkt = 0;
    int          last_count = 0;
    bit          grant_en = 1;
    longint      cyc = 0;
    int          fill_val = 0;
    logic [63:0] ts_cur = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void fifo_refresh();
        bus.fifo_usedw  = USEDW_W'(fifo_q.size());
        bus.fifo_rddata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endfunction

    task automatic push_bytes(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'(fill_val & 255);
            fill_val++;
            fifo_q.push_back(b);
            ref_q.push_back(b);
        end
        fifo_refresh();
    endtask

    task automatic expect_packet(input logic [31:0] seq);
        logic [7:0] h [HDR_BYTES];
        exp_t       e;
        for (int i = 0; i < int'(HDR_BYTES); i++) h[i] = 8'h00;
        h[0]  = seq[31:24];
        h[1]  = seq[23:16];
        h[2]  = seq[15:8];
        h[3]  = seq[7:0];
        h[13] = 8'h18;   // 24 bits per sample
        h[15] = 8'hEE;   // 238 samples per frame
        for (int i = 0; i < int'(DDC_PACKET_BYTES); i++) begin
            if (i < int'(HDR_BYTES)) begin
                e.data    = h[i];
                e.is_data = 1'b0;
`ifdef RX_TIMESTAMP_EN
                e.care    = !(i >= 4 && i < 12);
`else
                e.care    = 1'b1;
`endif
            end else begin
                e.data    = ref_q.pop_front();
                e.is_data = 1'b1;
                e.care    = 1'b1;
            end
            e.last = (i == int'(DDC_PACKET_BYTES) - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clock);
        if (exp_q.size() != 0) begin
            chk("packet_timeout_remaining", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (3) @(posedge clock);
        #2;
    endtask

    // Arbiter: grants after three cycles of request, holds until it sees tx_last.
    initial begin
        int req_cnt;
        int last_ref;
        req_cnt    = 0;
        last_ref   = 0;
        bus.tx_ack = 1'b0;
        forever begin
            @(posedge clock);
            #3;
            cyc++;
            if (!reset) begin
                bus.tx_ack = 1'b0;
                req_cnt    = 0;
                last_ref   = last_count;
            end else if (bus.tx_ack) begin
                if (last_count != last_ref) begin
                    bus.tx_ack = 1'b0;
                    last_ref   = last_count;
                end
            end else if (bus.tx_req && grant_en) begin
                if (req_cnt == 2) begin
                    bus.tx_ack = 1'b1;
                    grant_cyc.push_back(cyc);
                    req_cnt = 0;
                end else begin
                    req_cnt++;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    // Monitor: compares every presented byte, pops the FIFO model on fifo_rdreq.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            idx    = 0;
            in_pkt = 0;
        end else begin
            if (bus.fifo_rdreq) begin
                checks++;
                assert (bus.fifo_usedw != 0) else begin
                    errors++;
                    $display("FAIL underflow: fifo_rdreq=1 with fifo_usedw=%0d", bus.fifo_usedw);
                end
            end
            if (bus.tx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_valid", 64'(bus.tx_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.care) chk($sformatf("byte%0d_data", idx), 64'(bus.tx_data), 64'(e.data));
                    chk($sformatf("byte%0d_last", idx), 64'(bus.tx_last), 64'(e.last));
                    chk($sformatf("byte%0d_rdreq", idx), 64'(bus.fifo_rdreq), 64'(e.is_data));
                end
`ifdef RX_TIMESTAMP_EN
                if (idx >= 4 && idx < 12) ts_cur = {ts_cur[55:0], bus.tx_data};
                if (idx == 11) ts_list.push_back(ts_cur);
`endif
                if (bus.fifo_rdreq && fifo_q.size() > 0) begin
                    fifo_q.delete(0);
                    fifo_refresh();
                end
                if (bus.tx_last) begin
                    last_count++;
                    idx    = 0;
                    in_pkt = 0;
                end else begin
                    idx++;
                    in_pkt = 1;
                end
            end else begin
                if (in_pkt) chk($sformatf("contiguous_valid_at_byte%0d", idx), 64'(bus.tx_valid), 64'd1);
                in_pkt = 0;
                chk("rdreq_without_valid", 64'(bus.fifo_rdreq), 64'd0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [31:0] wrap_seq [3];
        fifo_refresh();
        repeat (3) @(posedge clock);
        #2;
        chk("rst_tx_req", 64'(bus.tx_req), 64'd0);
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_tx_last", 64'(bus.tx_last), 64'd0);
        chk("rst_fifo_rdreq", 64'(bus.fifo_rdreq), 64'd0);
        chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
        chk("rst_seq_out", 64'(seq_out), 64'd0);
        chk("port_id", 64'(bus.tx_port_id), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #2;

        // Basic packet: 0x00..0xFF pattern, sequence 0.
        push_bytes(int'(PAY));
        expect_packet(32'd0);
        run = 1'b1;
        wait_done();
        chk("A_usedw_end", 64'(bus.fifo_usedw), 64'd0);
        chk("A_seq_out", 64'(seq_out), 64'd0);

        // Threshold: 1427 bytes never request, the 1428th requests next cycle.
        push_bytes(int'(PAY) - 1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #2;
            if (bus.tx_req) seen = 1;
        end
        chk("B_no_req_at_1427", 64'(seen), 64'd0);
        push_bytes(1);
        expect_packet(32'd1);
        @(posedge clock);
        #2;
        chk("B_req_at_1428", 64'(bus.tx_req), 64'd1);
        wait_done();
        chk("B_seq_out", 64'(seq_out), 64'd1);

        // Request withdrawn when run drops before the grant; restart clears sequence.
        grant_en = 0;
        push_bytes(int'(PAY));
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clock);
            #2;
            if (bus.tx_req) seen = 1;
        end
        chk("C_req_raised", 64'(seen), 64'd1);
        run = 1'b0;
        @(posedge clock);
        #2;
        chk("C_req_withdrawn", 64'(bus.tx_req), 64'd0);
        chk("C_usedw_kept", 64'(bus.fifo_usedw), 64'(PAY));
        grant_en = 1;
        expect_packet(32'd0);
        run = 1'b1;
        wait_done();

        // Sequence wrap.
        force dut.seq_q = 32'hFFFF_FFFE;
        @(posedge clock);
        #2;
        release dut.seq_q;
        wrap_seq[0] = 32'hFFFF_FFFE;
        wrap_seq[1] = 32'hFFFF_FFFF;
        wrap_seq[2] = 32'h0000_0000;
        for (int p = 0; p < 3; p++) begin
            push_bytes(int'(PAY));
            expect_packet(wrap_seq[p]);
            wait_done();
            chk($sformatf("D_seq_out_%0d", p), 64'(seq_out), 64'(wrap_seq[p]));
        end

        // Reset at header byte 7: outputs drop asynchronously, sequence restarts at 0.
        push_bytes(int'(PAY));
        saved_q = ref_q;
        expect_packet(32'd1);
        for (int i = 0; i < 50 && idx != 7; i++) begin
            @(posedge clock);
            #2;
        end
        chk("E_valid_before_reset", 64'(bus.tx_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("E_async_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("E_async_tx_req", 64'(bus.tx_req), 64'd0);
        chk("E_async_rdreq", 64'(bus.fifo_rdreq), 64'd0);
        chk("E_async_tx_last", 64'(bus.tx_last), 64'd0);
        exp_q.delete();
        ref_q = saved_q;
        ts_list.delete();
        grant_cyc.delete();
        repeat (3) @(posedge clock);
        #2;
        chk("E_usedw_kept", 64'(bus.fifo_usedw), 64'(PAY));
        reset = 1'b1;
        expect_packet(32'd0);
        wait_done();
        chk("E_seq_out", 64'(seq_out), 64'd0);

        // Run drops at data byte 500: packet completes, no new request while stopped.
        push_bytes(int'(PAY));
        expect_packet(32'd1);
        for (int i = 0; i < 700 && idx != int'(HDR_BYTES) + 500; i++) begin
            @(posedge clock);
            #2;
        end
        chk("F_reached_byte500", 64'(idx), 64'(HDR_BYTES + 500));
        run = 1'b0;
        wait_done();
        chk("F_seq_out", 64'(seq_out), 64'd1);
        push_bytes(2000);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #2;
            if (bus.tx_req) seen = 1;
        end
        chk("F_no_req_run_low", 64'(seen), 64'd0);

`ifdef RX_TIMESTAMP_EN
        chk("G_ts_count", 64'(ts_list.size()), 64'(grant_cyc.size()));
        for (int i = 1; i < ts_list.size() && i < grant_cyc.size(); i++) begin
            chk($sformatf("G_ts_delta_%0d", i), ts_list[i] - ts_list[i-1],
                64'(grant_cyc[i] - grant_cyc[i-1]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_udp_packetizer.md
Name:
rx_udp_packetizer

Overview:
- Downstream neighbour of the per-receiver byte FIFO written by the Rx FIFO controller (protocol 2).
- Waits until the FIFO holds one full payload of I/Q bytes, then requests the Ethernet Tx arbiter.
- Once granted, streams one 1444-byte DDC UDP payload: a 16-byte header followed by 1428 data bytes popped from the FIFO.
- One instance per receiver.

Parameters:
- NR, 0: receiver index; driven on tx_port_id so the arbiter selects the UDP port.
- PAYLOAD_BYTES, 1428: data bytes per packet; must be a multiple of 6.
- BITS_PER_SAMPLE, 24: value written to header bytes 12-13.
- USEDW_W, 11: width of the FIFO used-words input (2048-deep FIFO).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  PC run bit; synchronous to clock.
- fifo_usedw  in  USEDW_W  bytes currently in the FIFO.
- fifo_rddata  in  8  show-ahead FIFO output; valid whenever the FIFO is not empty.
- fifo_rdreq  out  1  pop strobe.
- tx_req  out  1  request to the Ethernet Tx arbiter.
- tx_ack  in  1  grant; held high by the arbiter until it samples tx_last.
- tx_data  out  8  payload byte.
- tx_valid  out  1  tx_data is valid this cycle.
- tx_last  out  1  final byte of the packet.
- tx_port_id  out  4  constant NR.
- seq_out  out  32  sequence number of the packet currently or most recently sent.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; sequence counter 0; run_d 0.
- Header is 16 bytes, MSB first:
  - bytes 0-3: sequence number.
  - bytes 4-11: timestamp (see Optional Feature).
  - bytes 12-13: BITS_PER_SAMPLE.
  - bytes 14-15: SPF = PAYLOAD_BYTES/6 (238).
- Sequence handling:
  - Rising edge of run (run & !run_d) clears the sequence counter to 0. Takes effect only in IDLE; otherwise it is deferred to the next IDLE.
  - The counter increments once per packet in DONE and wraps 0xFFFFFFFF -> 0.
- State IDLE:
  - tx_req=0.
  - Go to REQ when run=1 and fifo_usedw >= PAYLOAD_BYTES (the comparison is unsigned).
- State REQ:
  - tx_req=1; wait for tx_ack.
  - When tx_ack=1: latch seq and timestamp into a header shadow register, set the byte counter to 0, go to HDR.
  - If run drops before the grant arrives: tx_req=0, return to IDLE.
- State HDR:
  - tx_valid=1; tx_data = shadow byte[count]; one byte per clock; no backpressure.
  - After byte 15: counter to 0, go to DATA.
- State DATA:
  - tx_valid=1; tx_data=fifo_rddata; fifo_rdreq=1 in the same cycle. Combinational pop, because the FIFO is show-ahead.
  - tx_last=1 on data byte PAYLOAD_BYTES-1, then go to DONE.
  - Latency: first header byte appears the cycle after tx_ack is sampled high. Total 1444 consecutive tx_valid cycles.
- State DONE:
  - tx_req=0, tx_valid=0; increment sequence; seq_out updated; go to IDLE.
  - Minimum gap between packets: 2 cycles.
- Boundary conditions:
  - run falling mid-packet: the packet always completes. It is never truncated.
  - FIFO underflow in DATA cannot occur, because the threshold is checked before the request. fifo_rdreq must never assert when fifo_usedw == 0; the bench checks this with an assertion.
  - fifo_usedw exactly PAYLOAD_BYTES-1: no request. Exactly PAYLOAD_BYTES: request.
  - Reset mid-packet: all outputs drop immediately (async); no tx_last is emitted; sequence returns to 0.
  - tx_ack low in IDLE or DONE: ignored.

Optional Feature:
- Macro: RX_TIMESTAMP_EN.
- Defined: a 64-bit free-running counter increments every clock and is cleared by reset. Its value is snapshotted on the REQ->HDR transition into header bytes 4-11.
- Undefined: header bytes 4-11 are constant 0x00 and no counter is synthesised.

Decomposition:
- Shared package p2_pkt_pkg:
  - HDR_BYTES=16, DDC_PAYLOAD_BYTES=1428, DDC_PACKET_BYTES=1444.
  - State enum {IDLE, REQ, HDR, DATA, DONE}.
  - The header field offset constants.
- One natural sub-module: p2_hdr_shift, a 16-byte load/shift header register with byte select. Otherwise the block is flat.

Test Plan:
- run=1, preload the FIFO with 1428 bytes 0x00..0xFF repeating, tx_ack granted 3 cycles after tx_req:
  - Expect 1444 contiguous tx_valid.
  - Bytes 0-3 = 00000000; bytes 12-13 = 0x0018; bytes 14-15 = 0x00EE.
  - Data matches the FIFO order; tx_last on byte 1443; fifo_usedw ends at 0.
- fifo_usedw held at 1427 for 100 cycles -> tx_req stays 0. Push 1 byte -> tx_req=1 the next cycle.
- Force sequence to 0xFFFFFFFE and send 3 packets -> header seq fields FFFFFFFE, FFFFFFFF, 00000000.
- Drop run at data byte 500 -> packet completes to tx_last. No new tx_req while run=0, even with 2000 bytes buffered.
- Assert reset at header byte 7 -> tx_valid, tx_req and fifo_rdreq go to 0 asynchronously; after release the next packet has seq 0.
- RX_TIMESTAMP_EN defined: grants spaced exactly 2000 cycles apart -> timestamp fields differ by 2000. Undefined: bytes 4-11 are all 0x00.
